// File: rtl/instr_fetch_unit.sv
// Byte-to-word instruction fetch: issues four byte addresses per instruction, assembles the
// returned bytes little-endian and presents the word with its PC on a valid/ready handshake.
module instr_fetch_unit #(
   parameter int unsigned ROM_LATENCY = 1,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] start_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stop,
   output logic [31:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_fetch_pc;
   logic [2:0]  r_issue_cnt;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;
   logic        r_pipe_v   [ROM_LATENCY];
   logic [1:0]  r_pipe_idx [ROM_LATENCY];

   logic        w_issue;
   logic        w_emerge_v;
   logic [1:0]  w_emerge_idx;
   logic        w_cap3;
   logic        w_accept;
   logic [1:0]  w_off;

   assign w_issue      = (r_state == S_FETCH) && !r_issue_cnt[2];
   assign w_emerge_v   = r_pipe_v[ROM_LATENCY-1];
   assign w_emerge_idx = r_pipe_idx[ROM_LATENCY-1];
   assign w_cap3       = (r_state == S_FETCH) && w_emerge_v && (w_emerge_idx == 2'd3);
   assign w_accept     = (r_state == S_HOLD) && instr_ready;
   assign w_off        = r_issue_cnt[2] ? 2'd3 : r_issue_cnt[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (stop)
         w_next = S_IDLE;
      else if (redirect_valid)
         w_next = S_FETCH;
      else begin
         case (r_state)
            S_IDLE:  if (start)    w_next = S_FETCH;
            S_FETCH: if (w_cap3)   w_next = S_HOLD;
            S_HOLD:  if (w_accept) w_next = S_FETCH;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      rom_addr    = r_fetch_pc;
      instr_valid = 1'b0;
      busy        = 1'b1;
      case (r_state)
         S_IDLE:  busy = 1'b0;
         S_FETCH: rom_addr = r_fetch_pc + {30'b0, w_off};
         S_HOLD: begin
            rom_addr    = r_fetch_pc + {30'b0, w_off};
            instr_valid = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

   assign instr    = r_instr;
   assign instr_pc = r_instr_pc;

   // Every restart (start, redirect, accept) zeroes the counter, the return pipe and the
   // assembly register so bytes of an abandoned fetch cannot leak into a later word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc  <= RESET_PC;
         r_issue_cnt <= '0;
         r_instr     <= '0;
         r_instr_pc  <= '0;
         for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
            r_pipe_v[i]   <= 1'b0;
            r_pipe_idx[i] <= '0;
         end
      end else if (stop || redirect_valid || (r_state == S_IDLE && start) || w_accept) begin
         if (stop)
            r_fetch_pc <= r_fetch_pc;
         else if (redirect_valid)
            r_fetch_pc <= redirect_pc;
         else if (r_state == S_IDLE)
            r_fetch_pc <= start_pc;
         else
            r_fetch_pc <= r_fetch_pc + 32'd4;
         r_issue_cnt <= '0;
         if (!stop) r_instr <= '0;
         for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
            r_pipe_v[i]   <= 1'b0;
            r_pipe_idx[i] <= '0;
         end
      end else if (r_state == S_FETCH) begin
         if (w_issue) r_issue_cnt <= r_issue_cnt + 3'd1;
         r_pipe_v[0]   <= w_issue;
         r_pipe_idx[0] <= r_issue_cnt[1:0];
         for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
            r_pipe_v[i]   <= r_pipe_v[i-1];
            r_pipe_idx[i] <= r_pipe_idx[i-1];
         end
         if (w_emerge_v) r_instr[{w_emerge_idx, 3'b000} +: 8] <= rom_data;
         if (w_cap3)     r_instr_pc <= r_fetch_pc;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of start-PC vectors plus hand-written
// sequences for stall, redirect, wrap, stop, start-while-busy and reset corner cases.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, redirect_valid, stop, instr_ready, instr_ready3;
   logic [31:0] start_pc, redirect_pc;
   logic [31:0] rom_addr, instr, instr_pc, rom_addr3, instr3, instr_pc3;
   logic [7:0]  rom_data, rom_data3;
   logic        instr_valid, busy, instr_valid3, busy3;

   instr_fetch_unit #(.ROM_LATENCY(1), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stop(stop),
      .rom_addr(rom_addr), .rom_data(rom_data), .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .busy(busy));

   instr_fetch_unit #(.ROM_LATENCY(3), .RESET_PC(32'h0)) dut3 (
      .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stop(stop),
      .rom_addr(rom_addr3), .rom_data(rom_data3), .instr(instr3), .instr_pc(instr_pc3),
      .instr_valid(instr_valid3), .instr_ready(instr_ready3), .busy(busy3));

   function automatic logic [7:0] rom_byte(input logic [31:0] a);
      case (a)
         32'h10:  return 8'hEF;
         32'h11:  return 8'hBE;
         32'h12:  return 8'hAD;
         32'h13:  return 8'hDE;
         default: return a[7:0] + 8'h20;
      endcase
   endfunction

   logic [7:0] q3 [3];
   always @(posedge clk) begin
      rom_data <= rom_byte(rom_addr);
      q3[0]    <= rom_byte(rom_addr3);
      q3[1]    <= q3[0];
      q3[2]    <= q3[1];
   end
   assign rom_data3 = q3[2];

   int nvec = 0;
   int nfail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start_fetch(input logic [31:0] pc);
      start_pc = pc;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic accept();
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
   endtask

   // Counts cycles until instr_valid; gives up after 30 so the latency check reports it.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!instr_valid && lat < 30) begin
         tick();
         lat++;
      end
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] exp_instr;
      int          exp_lat;
   } vec_t;

   vec_t vecs [5];
   int   lat, lat1, lat3;
   logic [31:0] hold_instr, hold_pc;
   logic [31:0] wrap_addr [4];
   logic        saw_valid;

   initial begin
      vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 5};
      vecs[1] = '{32'h0000_0014, 32'h3736_3534, 5};
      vecs[2] = '{32'h0000_0040, 32'h6362_6160, 5};
      vecs[3] = '{32'h0000_0013, 32'h3635_34DE, 5};
      vecs[4] = '{32'hFFFF_FFFE, 32'h2120_1F1E, 5};
      wrap_addr[0] = 32'hFFFF_FFFE;
      wrap_addr[1] = 32'hFFFF_FFFF;
      wrap_addr[2] = 32'h0000_0000;
      wrap_addr[3] = 32'h0000_0001;

      rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; stop = 1'b0;
      instr_ready = 1'b0; instr_ready3 = 1'b0; start_pc = '0; redirect_pc = '0;
      tick(); tick();
      chk("reset valid", {31'b0, instr_valid}, 32'd0);
      chk("reset busy", {31'b0, busy}, 32'd0);
      chk("reset rom_addr", rom_addr, 32'h0);
      chk("reset instr", instr, 32'h0);
      chk("reset instr_pc", instr_pc, 32'h0);
      rst = 1'b0;
      tick();

      // First word, both latencies measured from the first FETCH cycle.
      start_fetch(32'h10);
      lat1 = -1; lat3 = -1;
      for (int c = 0; c < 20; c++) begin
         if (instr_valid && lat1 < 0)  lat1 = c;
         if (instr_valid3 && lat3 < 0) lat3 = c;
         if (lat1 >= 0 && lat3 >= 0) break;
         tick();
      end
      chk("lat L1", lat1, 32'd5);
      chk("lat L3", lat3, 32'd7);
      chk("instr L1", instr, 32'hDEAD_BEEF);
      chk("instr_pc L1", instr_pc, 32'h10);
      chk("instr L3", instr3, 32'hDEAD_BEEF);
      chk("instr_pc L3", instr_pc3, 32'h10);

      hold_instr = instr;
      hold_pc    = instr_pc;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("stall instr", instr, hold_instr);
         chk("stall pc", instr_pc, hold_pc);
         chk("stall valid", {31'b0, instr_valid}, 32'd1);
      end

      accept();
      chk("valid drops after accept", {31'b0, instr_valid}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk("rom_addr seq 0x14", rom_addr, 32'h14 + k);
         tick();
      end
      wait_valid(lat);
      chk("lat 0x14 remaining", lat, 32'd1);
      chk("instr 0x14", instr, 32'h3736_3534);
      chk("instr_pc 0x14", instr_pc, 32'h14);

      pulse_stop();
      chk("stop busy", {31'b0, busy}, 32'd0);
      chk("stop valid", {31'b0, instr_valid}, 32'd0);

      // Redirect after two bytes of the 0x14 word were issued.
      start_fetch(32'h14);
      tick(); tick();
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect_valid = 1'b0;
      wait_valid(lat);
      chk("redirect lat", lat, 32'd5);
      chk("redirect instr_pc", instr_pc, 32'h40);
      chk("redirect instr", instr, 32'h6362_6160);

      chk("busy in HOLD", {31'b0, busy}, 32'd1);
      start_fetch(32'h10);
      chk("start ignored pc", instr_pc, 32'h40);
      chk("start ignored valid", {31'b0, instr_valid}, 32'd1);

      for (int i = 0; i < 5; i++) begin
         pulse_stop();
         start_fetch(vecs[i].pc);
         wait_valid(lat);
         chk("vec lat", lat, vecs[i].exp_lat);
         chk("vec instr", instr, vecs[i].exp_instr);
         chk("vec instr_pc", instr_pc, vecs[i].pc);
      end

      pulse_stop();
      start_fetch(32'hFFFF_FFFE);
      for (int k = 0; k < 4; k++) begin
         chk("rom_addr wrap", rom_addr, wrap_addr[k]);
         tick();
      end
      wait_valid(lat);
      chk("wrap instr", instr, 32'h2120_1F1E);
      chk("wrap instr_pc", instr_pc, 32'hFFFF_FFFE);
      accept();
      wait_valid(lat);
      chk("after wrap lat", lat, 32'd5);
      chk("after wrap instr_pc", instr_pc, 32'h2);
      chk("after wrap instr", instr, 32'h2524_2322);

      // Redirect coinciding with a handshake takes redirect_pc, not pc+4.
      instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h10;
      tick();
      instr_ready = 1'b0; redirect_valid = 1'b0;
      wait_valid(lat);
      chk("redir+hs lat", lat, 32'd5);
      chk("redir+hs instr_pc", instr_pc, 32'h10);
      chk("redir+hs instr", instr, 32'hDEAD_BEEF);

      pulse_stop();
      start_fetch(32'h40);
      tick(); tick();
      #1 rst = 1'b1;
      #1;
      chk("midreset valid", {31'b0, instr_valid}, 32'd0);
      chk("midreset busy", {31'b0, busy}, 32'd0);
      chk("midreset rom_addr", rom_addr, 32'h0);
      chk("midreset instr", instr, 32'h0);
      chk("midreset instr_pc", instr_pc, 32'h0);
      tick();
      rst = 1'b0;
      saw_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (instr_valid || busy) saw_valid = 1'b1;
      end
      chk("no word after reset", {31'b0, saw_valid}, 32'd0);

      redirect_valid = 1'b1; redirect_pc = 32'h14;
      tick();
      redirect_valid = 1'b0;
      wait_valid(lat);
      chk("idle redirect lat", lat, 32'd5);
      chk("idle redirect instr_pc", instr_pc, 32'h14);
      chk("idle redirect instr", instr, 32'h3736_3534);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
